// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit owning HI/LO for the MIPS E stage.
// busy is registered and stays high for exactly the op's latency after the start edge.
module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2     = 2 * WIDTH;
  localparam int MAXLAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW     = $clog2(MAXLAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_stateNext;
  logic [CW-1:0]    r_count, w_countNext;
  logic             r_busy, w_busyNext;
  logic [WIDTH-1:0] r_hi, w_hiNext;
  logic [WIDTH-1:0] r_lo, w_loNext;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_op;
  logic             w_latch;

  logic [W2-1:0]    w_sProd, w_uProd, w_madd;
  logic [WIDTH-1:0] w_absA, w_absB, w_magQ, w_magR, w_sQuot, w_sRem;
  logic [WIDTH-1:0] w_uQuot, w_uRem, w_resHi, w_resLo;
  logic             w_divZero;

  // Sign-extending to 2*WIDTH makes the unsigned product equal the signed one mod 2^(2*WIDTH).
  assign w_sProd = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_uProd = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_madd  = {r_hi, r_lo} + w_sProd;

  // Signed divide on magnitudes; the most-negative / -1 case falls out as 2^(WIDTH-1), remainder 0.
  assign w_absA  = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_absB  = r_b[WIDTH-1] ? -r_b : r_b;
  assign w_magQ  = w_absA / w_absB;
  assign w_magR  = w_absA % w_absB;
  assign w_sQuot = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -w_magQ : w_magQ;
  assign w_sRem  = r_a[WIDTH-1] ? -w_magR : w_magR;
  assign w_uQuot = r_a / r_b;
  assign w_uRem  = r_a % r_b;
  assign w_divZero = (r_b == '0);

  always_comb begin
    w_resHi = r_hi;
    w_resLo = r_lo;
    case (r_op)
      OP_MULT:  {w_resHi, w_resLo} = w_sProd;
      OP_MULTU: {w_resHi, w_resLo} = w_uProd;
      OP_MADD:  {w_resHi, w_resLo} = w_madd;
      OP_DIV: begin
        w_resHi = w_divZero ? r_a : w_sRem;
        w_resLo = w_divZero ? '1  : w_sQuot;
      end
      OP_DIVU: begin
        w_resHi = w_divZero ? r_a : w_uRem;
        w_resLo = w_divZero ? '1  : w_uQuot;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_busyNext  = r_busy;
    w_hiNext    = r_hi;
    w_loNext    = r_lo;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_MADD: begin
              w_latch     = 1'b1;
              w_countNext = CW'(MULT_CYCLES);
              w_busyNext  = 1'b1;
              w_stateNext = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              w_latch     = 1'b1;
              w_countNext = CW'(DIV_CYCLES);
              w_busyNext  = 1'b1;
              w_stateNext = S_RUN;
            end
            OP_MTHI: w_hiNext = a;
            OP_MTLO: w_loNext = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Requests arriving while running are dropped; the hazard unit should never send them.
        if (r_count == CW'(1)) begin
          w_hiNext    = w_resHi;
          w_loNext    = w_resLo;
          w_busyNext  = 1'b0;
          w_countNext = '0;
          w_stateNext = S_IDLE;
        end else begin
          w_countNext = r_count - CW'(1);
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      r_busy  <= w_busyNext;
      r_hi    <= w_hiNext;
      r_lo    <= w_loNext;
      if (w_latch) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op;
      end
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: directed cases plus randomized ops against a 64-bit arithmetic model.
// A second instance covers WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3.
module tb_mdu_multicycle;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  logic        sStart;
  logic [2:0]  sOp;
  logic [15:0] sA, sB;
  logic        sBusy;
  logic [15:0] sHi, sLo;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  always #5 clk = ~clk;

  mdu_multicycle #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  mdu_multicycle #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .start(sStart), .op(sOp), .a(sA), .b(sB),
    .busy(sBusy), .hi(sHi), .lo(sLo)
  );

  // Reference model: HI/LO as one 64-bit value updated with plain arithmetic.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = {mHi, mLo};
    case (o)
      3'd1: p = sx * sy;
      3'd2: p = {32'b0, x} * {32'b0, y};
      3'd7: p = {mHi, mLo} + 64'(sx * sy);
      3'd3: if (y == 0) p = {x, 32'hFFFF_FFFF};
            else begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
      3'd4: if (y == 0) p = {x, 32'hFFFF_FFFF}; else p = {x % y, x / y};
      3'd5: p = {x, mLo};
      3'd6: p = {mHi, x};
      default: ;
    endcase
    {mHi, mLo} = p;
  endtask

  function automatic int latency(input logic [2:0] o);
    case (o)
      3'd1, 3'd2, 3'd7: return MC;
      3'd3, 3'd4:       return DC;
      default:          return 0;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic issue16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    sStart = 1'b1; sOp = o; sA = x; sB = y;
    @(negedge clk);
    sStart = 1'b0; sOp = 3'd0;
  endtask

  task automatic count_busy16(output int n);
    n = 0;
    while (sBusy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    sStart = 1'b0; sOp = '0; sA = '0; sB = '0;
    repeat (3) @(negedge clk);
    mHi = '0; mLo = '0;
    totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCnt++;
    totalCnt++; if (hi !== 32'h0) $display("[TB] FAIL reset_hi: got %h expected 0", hi); else passCnt++;
    totalCnt++; if (lo !== 32'h0) $display("[TB] FAIL reset_lo: got %h expected 0", lo); else passCnt++;
    totalCnt++; if (sBusy !== 1'b0 || sHi !== 16'h0 || sLo !== 16'h0)
      $display("[TB] FAIL reset16: got busy=%b hi=%h lo=%h expected 0/0/0", sBusy, sHi, sLo);
    else passCnt++;
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    model_apply(3'd1, 32'hFFFF_FFFE, 32'd3);
    totalCnt++; if (n != 5) $display("[TB] FAIL mult_busy: got %0d expected 5", n); else passCnt++;
    totalCnt++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA)
      $display("[TB] FAIL mult_result: got %h_%h expected ffffffff_fffffffa", hi, lo);
    else passCnt++;
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(n);
    model_apply(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    totalCnt++; if (n != 5) $display("[TB] FAIL multu_busy: got %0d expected 5", n); else passCnt++;
    totalCnt++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001)
      $display("[TB] FAIL multu_result: got %h_%h expected fffffffe_00000001", hi, lo);
    else passCnt++;
  endtask

  task automatic test_div();
    int n;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    model_apply(3'd3, 32'hFFFF_FFF9, 32'd2);
    totalCnt++; if (n != 10) $display("[TB] FAIL div_busy: got %0d expected 10", n); else passCnt++;
    totalCnt++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
      $display("[TB] FAIL div_result: got %h_%h expected ffffffff_fffffffd", hi, lo);
    else passCnt++;
    issue(3'd4, 32'd7, 32'd0);
    count_busy(n);
    model_apply(3'd4, 32'd7, 32'd0);
    totalCnt++; if (n != 10) $display("[TB] FAIL divu_zero_busy: got %0d expected 10", n); else passCnt++;
    totalCnt++; if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF)
      $display("[TB] FAIL divu_zero: got %h_%h expected 00000007_ffffffff", hi, lo);
    else passCnt++;
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    model_apply(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    totalCnt++; if (hi !== 32'h0 || lo !== 32'h8000_0000)
      $display("[TB] FAIL div_overflow: got %h_%h expected 00000000_80000000", hi, lo);
    else passCnt++;
    issue(3'd3, 32'hFFFF_FFF0, 32'd0);
    count_busy(n);
    model_apply(3'd3, 32'hFFFF_FFF0, 32'd0);
    totalCnt++; if (hi !== 32'hFFFF_FFF0 || lo !== 32'hFFFF_FFFF)
      $display("[TB] FAIL div_zero: got %h_%h expected fffffff0_ffffffff", hi, lo);
    else passCnt++;
  endtask

  task automatic test_mt_madd();
    int n;
    issue(3'd5, 32'h1234, 32'h0);
    model_apply(3'd5, 32'h1234, 32'h0);
    totalCnt++; if (busy !== 1'b0 || hi !== 32'h1234)
      $display("[TB] FAIL mthi: got busy=%b hi=%h expected 0/00001234", busy, hi);
    else passCnt++;
    issue(3'd6, 32'h10, 32'h0);
    model_apply(3'd6, 32'h10, 32'h0);
    totalCnt++; if (busy !== 1'b0 || lo !== 32'h10)
      $display("[TB] FAIL mtlo: got busy=%b lo=%h expected 0/00000010", busy, lo);
    else passCnt++;
    issue(3'd0, 32'hDEAD_BEEF, 32'h1);
    totalCnt++; if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h10)
      $display("[TB] FAIL nop_ignored: got busy=%b hi=%h lo=%h expected 0/00001234/00000010", busy, hi, lo);
    else passCnt++;
    issue(3'd7, 32'd4, 32'd5);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 1) begin start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; b = 32'd9; end
      if (n == 3) begin
        start = 1'b0; op = 3'd0;
        totalCnt++; if (hi !== 32'h1234 || lo !== 32'h10)
          $display("[TB] FAIL madd_hold: got %h_%h expected 00001234_00000010", hi, lo);
        else passCnt++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    model_apply(3'd7, 32'd4, 32'd5);
    totalCnt++; if (n != 5) $display("[TB] FAIL madd_busy: got %0d expected 5", n); else passCnt++;
    totalCnt++; if (hi !== 32'h1234 || lo !== 32'h24)
      $display("[TB] FAIL madd_result: got %h_%h expected 00001234_00000024", hi, lo);
    else passCnt++;
  endtask

  task automatic test_reset_abort();
    issue(3'd5, 32'hAAAA_5555, 32'h0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    totalCnt++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      $display("[TB] FAIL abort_clear: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    else passCnt++;
    start = 1'b1; op = 3'd5; a = 32'h55;
    @(negedge clk);
    totalCnt++; if (hi !== 32'h0) $display("[TB] FAIL reset_beats_mthi: got %h expected 0", hi); else passCnt++;
    op = 3'd1; a = 32'd3; b = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; op = 3'd0;
    totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_beats_mult: got busy=%b expected 0", busy); else passCnt++;
    repeat (15) @(negedge clk);
    mHi = '0; mLo = '0;
    totalCnt++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      $display("[TB] FAIL abort_no_write: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    else passCnt++;
  endtask

  task automatic test_random();
    int n;
    logic [2:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'h0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = 32'($urandom_range(0, 50)) - 32'd25; y = 32'($urandom_range(1, 9)); end
        3: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      issue(o, x, y);
      count_busy(n);
      model_apply(o, x, y);
      totalCnt++; if (n != latency(o))
        $display("[TB] FAIL rand_busy[%0d] op=%0d: got %0d expected %0d", i, o, n, latency(o));
      else passCnt++;
      totalCnt++; if (hi !== mHi || lo !== mLo)
        $display("[TB] FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, o, x, y, hi, lo, mHi, mLo);
      else passCnt++;
    end
  endtask

  task automatic test_width16();
    int n;
    issue16(3'd1, 16'h8000, 16'h8000);
    count_busy16(n);
    totalCnt++; if (n != 1) $display("[TB] FAIL w16_mult_busy: got %0d expected 1", n); else passCnt++;
    totalCnt++; if (sHi !== 16'h4000 || sLo !== 16'h0000)
      $display("[TB] FAIL w16_mult: got %h_%h expected 4000_0000", sHi, sLo);
    else passCnt++;
    issue16(3'd3, 16'hFFF9, 16'd2);
    count_busy16(n);
    totalCnt++; if (n != 3) $display("[TB] FAIL w16_div_busy: got %0d expected 3", n); else passCnt++;
    totalCnt++; if (sHi !== 16'hFFFF || sLo !== 16'hFFFD)
      $display("[TB] FAIL w16_div: got %h_%h expected ffff_fffd", sHi, sLo);
    else passCnt++;
    issue16(3'd3, 16'h8000, 16'hFFFF);
    count_busy16(n);
    totalCnt++; if (sHi !== 16'h0 || sLo !== 16'h8000)
      $display("[TB] FAIL w16_div_overflow: got %h_%h expected 0000_8000", sHi, sLo);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_madd();
    test_reset_abort();
    test_random();
    test_width16();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core. It sits in the E stage and owns the HI/LO registers.
- It is driven by the decoder's MDU enable and MDU op code. It models realistic multi-cycle latency with a busy handshake, so the hazard unit stalls HI/LO consumers.
- It adds width/latency parameters and a signed multiply-accumulate (MADD) mode.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (even, >=8).
- MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  MDU enable from decoder; op valid this cycle.
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  operation in flight; hazard unit stalls any MDU instruction or MFHI/MFLO in D while busy|start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Clocking and reset:
  - All state updates on the clk rising edge.
  - reset=1 forces hi=0, lo=0, busy=0, counter=0, state IDLE. Reset wins over start.
  - Reset mid-operation aborts the operation; its result is never written.
- FSM:
  - IDLE -> RUN on start=1 with op in {1,2,3,4,7}. At that edge, latch a, b, op and load counter with MULT_CYCLES or DIV_CYCLES.
  - RUN: busy=1; counter decrements each edge. At the edge where counter reaches 1, write hi/lo, set busy=0, go to IDLE.
  - busy is a registered output. It is 1 for exactly N cycles following the start edge (N = the op's latency).
  - MFHI/MFLO in the cycle after busy falls read the new value.
- MTHI/MTLO:
  - start=1 with op 5/6 in IDLE writes a to hi/lo at that edge.
  - Single cycle; busy stays 0.
- Ignored inputs:
  - start with op 0, or start while busy=1, has no effect on state or hi/lo.
  - The controller guarantees this never happens; verification checks it is ignored.
- Arithmetic (all on latched operands):
  - MULT: {hi,lo} = signed a * signed b, 2*WIDTH result.
  - MULTU: {hi,lo} = unsigned product.
  - MADD: {hi,lo} = {hi,lo} + signed a*b, modulo 2^(2*WIDTH). Uses hi/lo as they are at the completion edge.
  - DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
    - Overflow case a = -2^(WIDTH-1), b = -1: lo = 0x8000_0000, hi = 0 (WIDTH=32).
  - DIVU: unsigned lo = a/b, hi = a%b.
  - Divide by zero (DIV or DIVU): full latency still elapses; lo = all ones, hi = a.
- hi/lo are only modified at completion, by MTHI/MTLO, or by reset; otherwise they hold.

Test Plan:
- reset, then start MULT a=0xFFFF_FFFE (-2), b=3 -> busy=1 for 5 cycles; then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001 after 5 busy cycles.
- DIV a=-7 (0xFFFF_FFF9), b=2 -> busy 10 cycles; lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
  - DIVU a=7, b=0 -> lo=0xFFFF_FFFF, hi=7.
- MTHI a=0x1234 then MTLO a=0x10, then MADD a=4, b=5 -> hi=0x1234, lo=0x24.
  - A second start during MADD busy is ignored; hi/lo unchanged until completion.
- Start DIV, assert reset in 4th busy cycle -> busy=0, hi=lo=0 next cycle; no later write.
  - Start on the same edge as reset is ignored.
- Parameter sweep WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3: MULT 0x8000*0x8000 -> hi=0x4000, lo=0x0000 with exactly 1 busy cycle.
